crc_frame_serializer: RTL and testbench

CRC_FRAME_SERIALIZER -- requirements
Module: crc_frame_serializer

---
 rtl/crc_frame_serializer.sv | 171 +++++++++++++++++
 tb/tb_crc_frame_serializer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_frame_serializer.sv
// rtl/crc_frame_serializer.sv - FIFO-buffered byte serializer feeding an external LFSR, with serial CRC collection
module crc_frame_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CRC_WIDTH  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] IN_DATA,
  input  logic                  IN_LAST,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  output logic                  SER_DATA,
  output logic                  SER_ACTIVE,
  input  logic                  CRC_IN,
  input  logic                  CRC_VALID_IN,
  output logic [CRC_WIDTH-1:0]  CRC_OUT,
  output logic                  CRC_DONE,
  output logic                  UNDERRUN,
  output logic                  CRC_TIMEOUT,
  output logic                  BUSY
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int CW = (CRC_WIDTH > 1) ? $clog2(CRC_WIDTH) : 1;
  localparam logic [AW:0]   DEPTH    = FIFO_DEPTH;
  localparam logic [AW:0]   PTR_ONE  = 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] LAST_CRC = CW'(CRC_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, COLLECT} state_t;

  state_t                state, next_state;
  logic [DATA_WIDTH:0]   mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr, rd_ptr, last_cnt, count;
  logic                  full, empty, wr_en, pop;
  logic [DATA_WIDTH:0]   head;
  logic [DATA_WIDTH-1:0] cur_byte;
  logic                  cur_last;
  logic [BW-1:0]         bit_cnt;
  logic [CRC_WIDTH-1:0]  staging, staging_next;
  logic [CW-1:0]         crc_cnt;
  logic [4:0]            idle_cnt;
  logic                  enter_collect, set_done, set_underrun, set_timeout;

  assign count    = wr_ptr - rd_ptr;
  assign full     = (count == DEPTH);
  assign empty    = (count == '0);
  assign IN_READY = !full;
  assign wr_en    = IN_VALID && !full;
  assign head     = mem[rd_ptr[AW-1:0]];

  // last_cnt tracks how many stored entries close a frame, so IDLE can start without scanning
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      last_cnt <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr[AW-1:0]] <= {IN_LAST, IN_DATA};
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_en && IN_LAST, pop && head[DATA_WIDTH]})
        2'b10:   last_cnt <= last_cnt + PTR_ONE;
        2'b01:   last_cnt <= last_cnt - PTR_ONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state    = state;
    pop           = 1'b0;
    enter_collect = 1'b0;
    set_done      = 1'b0;
    set_underrun  = 1'b0;
    set_timeout   = 1'b0;
    case (state)
      IDLE: begin
        if (last_cnt != '0 || full) begin
          pop        = 1'b1;
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_cnt == LAST_BIT) begin
          if (cur_last) begin
            next_state    = COLLECT;
            enter_collect = 1'b1;
          end else if (!empty) begin
            pop = 1'b1;
          end else begin
            set_underrun  = 1'b1;
            next_state    = COLLECT;
            enter_collect = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (CRC_VALID_IN) begin
          if (crc_cnt == LAST_CRC) begin
            set_done   = 1'b1;
            next_state = IDLE;
          end
        end else if (idle_cnt == 5'd15) begin
          set_timeout = 1'b1;
          next_state  = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // first received CRC bit lands in bit 0
  always_comb begin
    staging_next          = staging;
    staging_next[crc_cnt] = CRC_IN;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cur_byte    <= '0;
      cur_last    <= 1'b0;
      bit_cnt     <= '0;
      staging     <= '0;
      crc_cnt     <= '0;
      idle_cnt    <= '0;
      CRC_OUT     <= '0;
      CRC_DONE    <= 1'b0;
      UNDERRUN    <= 1'b0;
      CRC_TIMEOUT <= 1'b0;
    end else begin
      CRC_DONE    <= set_done;
      UNDERRUN    <= set_underrun;
      CRC_TIMEOUT <= set_timeout;
      if (pop) begin
        cur_byte <= head[DATA_WIDTH-1:0];
        cur_last <= head[DATA_WIDTH];
        bit_cnt  <= '0;
      end else if (state == SHIFT) begin
        bit_cnt <= bit_cnt + BW'(1);
      end
      if (enter_collect) begin
        staging  <= '0;
        crc_cnt  <= '0;
        idle_cnt <= '0;
      end else if (state == COLLECT) begin
        if (CRC_VALID_IN) begin
          staging  <= staging_next;
          crc_cnt  <= crc_cnt + CW'(1);
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + 5'd1;
        end
      end
      if (set_done) CRC_OUT <= staging_next;
    end
  end

  assign SER_ACTIVE = (state == SHIFT);
  assign SER_DATA   = (state == SHIFT) && cur_byte[bit_cnt];
  assign BUSY       = (state != IDLE);
endmodule

// File: tb/tb_crc_frame_serializer.sv
// tb/tb_crc_frame_serializer.sv - table-driven and randomized checks of crc_frame_serializer against a frame-level model
module tb_crc_frame_serializer;
  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] IN_DATA;
  logic       IN_LAST, IN_VALID, IN_READY;
  logic       SER_DATA, SER_ACTIVE;
  logic       CRC_IN, CRC_VALID_IN;
  logic [7:0] CRC_OUT;
  logic       CRC_DONE, UNDERRUN, CRC_TIMEOUT, BUSY;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] model_crc = 8'h00;

  always #5 CLK = ~CLK;

  crc_frame_serializer dut (
    .CLK(CLK), .RST(RST),
    .IN_DATA(IN_DATA), .IN_LAST(IN_LAST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .SER_DATA(SER_DATA), .SER_ACTIVE(SER_ACTIVE),
    .CRC_IN(CRC_IN), .CRC_VALID_IN(CRC_VALID_IN),
    .CRC_OUT(CRC_OUT), .CRC_DONE(CRC_DONE), .UNDERRUN(UNDERRUN),
    .CRC_TIMEOUT(CRC_TIMEOUT), .BUSY(BUSY)
  );

  typedef struct {
    int          n;
    logic [47:0] bytes;
    bit          timeout;
    logic [7:0]  crc;
    logic [47:0] exp_stream;
    logic [7:0]  exp_crc_out;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Serial stream of a frame: bytes in order, each LSB first; bit k of the result is the k-th serial bit
  function automatic logic [63:0] model_stream(input logic [7:0] q[$]);
    logic [63:0] s = '0;
    int          k = 0;
    foreach (q[i]) begin
      for (int b = 0; b < 8; b++) begin
        s[k] = q[i][b];
        k++;
      end
    end
    return s;
  endfunction

  task automatic write_frame(input logic [7:0] q[$], input bit last_on_final,
                             output logic ready_after, output bit ok);
    int i = 0;
    int budget = 0;
    while (i < q.size() && budget < 200) begin
      @(negedge CLK);
      IN_VALID = 1'b1;
      IN_DATA  = q[i];
      IN_LAST  = last_on_final && (i == q.size() - 1);
      if (IN_READY) i++;
      budget++;
    end
    @(negedge CLK);
    IN_VALID    = 1'b0;
    IN_LAST     = 1'b0;
    ready_after = IN_READY;
    ok          = (i == q.size());
  endtask

  task automatic shift_monitor(output logic [63:0] stream, output int len, output bit started,
                               output logic underrun_end, output int underrun_early,
                               output logic sd_idle);
    int wait_cyc = 0;
    stream = '0;
    len = 0;
    underrun_early = 0;
    do begin
      @(negedge CLK);
      wait_cyc++;
    end while (!SER_ACTIVE && wait_cyc < 300);
    started = SER_ACTIVE;
    while (SER_ACTIVE && len < 64) begin
      stream[len] = SER_DATA;
      len++;
      if (UNDERRUN) underrun_early++;
      @(negedge CLK);
    end
    underrun_end = UNDERRUN;
    sd_idle      = SER_DATA;
  endtask

  task automatic run_shift(input string tag, input logic [7:0] q[$], input bit last_on_final,
                           input logic [63:0] exp_stream, output logic ready_after,
                           output logic underrun_end);
    logic [63:0] stream;
    int          len, und_early;
    bit          started, wok;
    logic        sd_idle;
    fork
      write_frame(q, last_on_final, ready_after, wok);
      shift_monitor(stream, len, started, underrun_end, und_early, sd_idle);
    join
    chk({tag, "_write_done"}, 64'(wok), 64'(1));
    chk({tag, "_shift_started"}, 64'(started), 64'(1));
    chk({tag, "_ser_len"}, 64'(len), 64'(8 * q.size()));
    chk({tag, "_ser_bits"}, stream, exp_stream);
    chk({tag, "_underrun_early"}, 64'(und_early), 64'(0));
    chk({tag, "_ser_data_idle"}, 64'(sd_idle), 64'(0));
  endtask

  task automatic collect_crc(input string tag, input logic [7:0] crc, input bit use_gaps,
                             input logic [7:0] exp_out);
    int early = 0;
    for (int i = 0; i < 8; i++) begin
      int gap = use_gaps ? int'($urandom_range(0, 15)) : 0;
      for (int g = 0; g < gap; g++) begin
        CRC_VALID_IN = 1'b0;
        CRC_IN       = 1'($urandom_range(0, 1));
        @(negedge CLK);
        if (CRC_DONE || CRC_TIMEOUT || !BUSY) early++;
      end
      CRC_VALID_IN = 1'b1;
      CRC_IN       = crc[i];
      @(negedge CLK);
      if (i < 7 && (CRC_DONE || CRC_TIMEOUT || !BUSY)) early++;
    end
    chk({tag, "_crc_done"}, 64'(CRC_DONE), 64'(1));
    chk({tag, "_crc_out"}, 64'(CRC_OUT), 64'(exp_out));
    chk({tag, "_busy_after_done"}, 64'(BUSY), 64'(0));
    for (int j = 0; j < 3; j++) begin
      CRC_VALID_IN = 1'b1;
      CRC_IN       = 1'($urandom_range(0, 1));
      @(negedge CLK);
      if (CRC_DONE || BUSY || CRC_TIMEOUT) early++;
    end
    CRC_VALID_IN = 1'b0;
    chk({tag, "_stray_pulses"}, 64'(early), 64'(0));
    chk({tag, "_crc_held"}, 64'(CRC_OUT), 64'(exp_out));
  endtask

  task automatic expect_timeout(input string tag, input logic [7:0] exp_out);
    int k = 1;
    int hit = 0;
    int other = 0;
    CRC_VALID_IN = 1'b0;
    while (hit == 0 && k < 40) begin
      @(negedge CLK);
      k++;
      CRC_IN = 1'($urandom_range(0, 1));
      if (CRC_TIMEOUT) hit = k;
      if (CRC_DONE || UNDERRUN) other++;
    end
    chk({tag, "_timeout_cycle"}, 64'(hit), 64'(17));
    chk({tag, "_busy_after_timeout"}, 64'(BUSY), 64'(0));
    chk({tag, "_crc_unchanged"}, 64'(CRC_OUT), 64'(exp_out));
    chk({tag, "_other_pulses"}, 64'(other), 64'(0));
    @(negedge CLK);
    chk({tag, "_timeout_single"}, 64'(CRC_TIMEOUT), 64'(0));
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[6];
    logic [7:0]  q[$];
    logic        ready_after, und_end;
    int          act, budget, pulses;
    string       tag;

    vecs[0] = '{1, 48'h01,           1'b0, 8'h0D, 48'h01,           8'h0D};
    vecs[1] = '{2, 48'h3CA5,         1'b1, 8'h00, 48'h3CA5,         8'h0D};
    vecs[2] = '{3, 48'h8100FF,       1'b0, 8'hB2, 48'h8100FF,       8'hB2};
    vecs[3] = '{4, 48'h78563412,     1'b0, 8'h5A, 48'h78563412,     8'h5A};
    vecs[4] = '{6, 48'h8001EFBEADDE, 1'b0, 8'hFF, 48'h8001EFBEADDE, 8'hFF};
    vecs[5] = '{1, 48'h80,           1'b1, 8'h00, 48'h80,           8'hFF};

    RST = 1'b0;
    IN_DATA = '0; IN_LAST = 1'b0; IN_VALID = 1'b0;
    CRC_IN = 1'b0; CRC_VALID_IN = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("rst_in_ready", 64'(IN_READY), 64'(1));
    chk("rst_outputs", 64'({SER_DATA, SER_ACTIVE, CRC_DONE, UNDERRUN, CRC_TIMEOUT, BUSY}), 64'(0));
    chk("rst_crc_out", 64'(CRC_OUT), 64'(0));

    foreach (vecs[v]) begin
      tag = $sformatf("vec%0d", v);
      q.delete();
      for (int i = 0; i < vecs[v].n; i++) q.push_back(vecs[v].bytes[8*i +: 8]);
      run_shift(tag, q, 1'b1, 64'(vecs[v].exp_stream), ready_after, und_end);
      chk({tag, "_no_underrun"}, 64'(und_end), 64'(0));
      if (vecs[v].timeout) expect_timeout(tag, vecs[v].exp_crc_out);
      else                 collect_crc(tag, vecs[v].crc, 1'b0, vecs[v].exp_crc_out);
    end
    model_crc = vecs[5].exp_crc_out;

    // four non-last bytes fill the FIFO, start shifting on full, then run dry
    q = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_shift("underrun", q, 1'b0, model_stream(q), ready_after, und_end);
    chk("underrun_ready_low_when_full", 64'(ready_after), 64'(0));
    chk("underrun_pulse", 64'(und_end), 64'(1));
    expect_timeout("underrun", model_crc);

    for (int r = 0; r < 16; r++) begin
      bit         to;
      logic [7:0] crc;
      tag = $sformatf("rnd%0d", r);
      q.delete();
      for (int i = 0; i < int'($urandom_range(1, 6)); i++) q.push_back(8'($urandom));
      to  = ($urandom_range(0, 4) == 0);
      crc = 8'($urandom);
      run_shift(tag, q, 1'b1, model_stream(q), ready_after, und_end);
      chk({tag, "_no_underrun"}, 64'(und_end), 64'(0));
      if (to) begin
        expect_timeout(tag, model_crc);
      end else begin
        collect_crc(tag, crc, 1'b1, crc);
        model_crc = crc;
      end
    end

    // reset during the third SHIFT cycle abandons the frame
    q = '{8'h55, 8'h0F, 8'hAA};
    begin
      bit wok;
      write_frame(q, 1'b1, ready_after, wok);
    end
    act = 0;
    budget = 0;
    while (act < 3 && budget < 50) begin
      @(negedge CLK);
      budget++;
      if (SER_ACTIVE) act++;
    end
    chk("rstmid_reached_third_bit", 64'(act), 64'(3));
    RST = 1'b0;
    #1;
    chk("rstmid_ser_active", 64'(SER_ACTIVE), 64'(0));
    chk("rstmid_ser_data", 64'(SER_DATA), 64'(0));
    chk("rstmid_busy", 64'(BUSY), 64'(0));
    @(negedge CLK);
    RST = 1'b1;
    model_crc = 8'h00;
    @(negedge CLK);
    chk("rstmid_in_ready", 64'(IN_READY), 64'(1));
    chk("rstmid_crc_out", 64'(CRC_OUT), 64'(model_crc));
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (CRC_DONE || UNDERRUN || CRC_TIMEOUT || BUSY || SER_ACTIVE) pulses++;
    end
    chk("rstmid_quiet", 64'(pulses), 64'(0));

    q = '{8'h01};
    run_shift("recover", q, 1'b1, model_stream(q), ready_after, und_end);
    collect_crc("recover", 8'h0D, 1'b0, 8'h0D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
